// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants, state type and hex segment table for the display scanner
package seg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam logic [3:0] AN_OFF = 4'b1111;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        ON
    } seg_state_e;

    // Active-low {g,f,e,d,c,b,a}; entry 15 first so SEG_TABLE[n] is the glyph for n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/hex7seg.sv
// rtl/hex7seg.sv - combinational hex nibble to active-low seven-segment decoder
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - four-digit seven-segment scan controller; SEG_LZB_EN adds leading-zero blanking
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int TICK_DIV     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] number,
    input  logic [3:0]  dp,
    output logic [6:0]  display,
    output logic        dp_n,
    output logic [3:0]  AN,
    output logic        frame_done
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] ON_LAST    = CW'(TICK_DIV - BLANK_CYCLES - 1);

    seg_state_e    state, state_nxt;
    logic [CW-1:0] cnt;
    logic [1:0]    idx, idx_nxt;
    logic [15:0]   staging_num, shadow_num, num_nxt;
    logic [3:0]    staging_dp, shadow_dp, dp_nxt;
    logic          pending;
    logic          boundary, commit;
    logic [3:0]    nib;
    logic [6:0]    seg_dec;
    logic          lead_blank;
    logic [3:0]    an_nxt;
    logic [6:0]    seg_nxt;
    logic          dpn_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= 2'd3;
            staging_num <= '0;
            staging_dp  <= '0;
            shadow_num  <= '0;
            shadow_dp   <= '0;
            pending     <= 1'b0;
            AN          <= AN_OFF;
            display     <= SEG_OFF;
            dp_n        <= 1'b1;
            frame_done  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state || state_nxt == IDLE)
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);
            idx        <= idx_nxt;
            shadow_num <= num_nxt;
            shadow_dp  <= dp_nxt;
            if (load) begin
                staging_num <= number;
                staging_dp  <= dp;
            end
            if (commit)
                pending <= 1'b0;
            else if (load)
                pending <= 1'b1;
            AN         <= an_nxt;
            display    <= seg_nxt;
            dp_n       <= dpn_nxt;
            frame_done <= boundary;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        boundary  = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
            idx_nxt   = 2'd3;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = BLANK;
                    idx_nxt   = 2'd3;
                end
                BLANK: if (cnt == BLANK_LAST) state_nxt = ON;
                ON: if (cnt == ON_LAST) begin
                    state_nxt = BLANK;
                    idx_nxt   = idx - 2'd1;
                    boundary  = (idx == 2'd0);
                end
                default: state_nxt = IDLE;
            endcase
        end

        // A load in the commit cycle itself beats whatever was already staged.
        commit  = (state == IDLE) || boundary;
        num_nxt = shadow_num;
        dp_nxt  = shadow_dp;
        if (commit) begin
            if (load) begin
                num_nxt = number;
                dp_nxt  = dp;
            end else if (pending) begin
                num_nxt = staging_num;
                dp_nxt  = staging_dp;
            end
        end
    end

    assign nib = num_nxt[{idx_nxt, 2'b00} +: 4];

    hex7seg u_hex7seg (
        .hex (nib),
        .seg (seg_dec)
    );

    always_comb begin
        lead_blank = 1'b0;
`ifdef SEG_LZB_EN
        case (idx_nxt)
            2'd3:    lead_blank = (num_nxt[15:12] == 4'd0);
            2'd2:    lead_blank = (num_nxt[15:8] == 8'd0);
            2'd1:    lead_blank = (num_nxt[15:4] == 12'd0);
            default: lead_blank = 1'b0;
        endcase
`endif
        an_nxt  = AN_OFF;
        seg_nxt = SEG_OFF;
        dpn_nxt = 1'b1;
        if (state_nxt != IDLE && !lead_blank) begin
            seg_nxt = seg_dec;
            dpn_nxt = ~dp_nxt[idx_nxt];
        end
        if (state_nxt == ON)
            an_nxt[idx_nxt] = 1'b0;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Scan controller for the four-digit multiplexed seven-segment display. It takes a 16-bit hex value and per-digit decimal points, then drives the shared cathode bus and the four anodes in a fixed round-robin. Each digit slot starts with an anti-ghosting blank interval. New values are committed only at frame boundaries, so the display never shows a torn value. It sits between the system's value producers (timers, counters) and the board's display pins.

## Interface
- TICK_DIV, 50000: clock cycles per digit slot (blank + on); must be > BLANK_CYCLES.
- BLANK_CYCLES, 500: cycles at the start of each slot with all anodes off; must be ≥ 1.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  high: scanning runs; low: display dark.
- load  in  1  one-cycle strobe; captures number and dp.
- number  in  16  four hex digits; [15:12] is the leftmost digit (AN[3]), [3:0] the rightmost (AN[0]).
- dp  in  4  decimal point per digit, bit i belongs to AN[i]; active-high request.
- display  out  7  active-low segments, bit order {g,f,e,d,c,b,a}.
- dp_n  out  1  active-low decimal point.
- AN  out  4  active-low anode enables; at most one bit low.
- frame_done  out  1  one-cycle pulse at the end of every full 4-digit frame.

## Operation
- States:
  - IDLE: all dark.
  - BLANK: AN=4'b1111; display and dp_n already carry the pattern of the current digit.
  - ON: AN bit of the current digit is low.
- Transitions:
  - IDLE→BLANK on enable=1, with digit index = 3.
  - BLANK→ON after BLANK_CYCLES cycles.
  - ON→BLANK after TICK_DIV−BLANK_CYCLES cycles, with index decremented modulo 4 (0 wraps to 3).
  - Any state→IDLE on enable=0.
- Slot counter: one counter of width $clog2(TICK_DIV), cleared on every state change.
- Staging register (number, dp) is written on every load.
  - A repeated load before commit overwrites it; the newest value wins.
- Commit (staging→shadow) happens on the frame boundary, i.e. the cycle ON of digit 0 ends.
  - frame_done pulses in that same cycle.
  - A load in the boundary cycle itself is committed at that boundary.
- In IDLE, a load commits immediately.
- Decode: hex 0–F to standard patterns, e.g. 0→7'b1000000, 8→7'b0000000, F→7'b0001110.

## Timing
- Reset values: AN=4'b1111, display=7'h7F, dp_n=1, frame_done=0, shadow=0, staging=0, pending=0, index=3, state=IDLE.
- All outputs are registered.
- AN, display and dp_n change on the edge that enters the new state, i.e. one cycle after the counter reaches its terminal count.
- Slot length is exactly TICK_DIV cycles; frame length is exactly 4·TICK_DIV cycles.
- enable falling: AN=4'b1111 and display=7'h7F on the next edge; the current frame is abandoned with no frame_done.
- enable rising: the first digit-3 anode goes low BLANK_CYCLES+1 cycles later.
- Reset mid-frame: all state returns to reset values on the next edge; any pending load is discarded.

## Configuration
- SEG_LZB_EN defined: leading-zero blanking.
  - Digits from the left whose shadow value is 0 are blanked (display=7'h7F, dp_n=1) until the first nonzero digit.
  - Digit 0 is always shown.
  - The anode still scans the blanked digits, so slot timing is unchanged.
- SEG_LZB_EN undefined: all four digits always displayed.

## Structure
- Package seg_pkg:
  - NUM_DIGITS=4.
  - AN_OFF=4'b1111.
  - SEG_OFF=7'h7F.
  - State enum {IDLE, BLANK, ON}.
  - The 16-entry hex→segment constant table.
- Sub-module hex7seg: combinational 4-bit to 7-bit active-low decoder, one instance on the muxed digit nibble.

## Test plan
Benches use TICK_DIV=8, BLANK_CYCLES=2.
- Reset, enable=1, number=16'h1234, load: AN sequence 1111(2 cycles)→0111(6 cycles) with display=7'b1111001 ("1"), then digit 2 "2", digit 1 "3", digit 0 "4"; frame_done pulses every 32 cycles.
- AN check over 1000 cycles: never two bits low, and never low during BLANK.
- load 16'hABCD mid-frame: AN[3..1] keep the old digits until the frame boundary; the next frame shows A,b,C,d; the tear-free check passes.
- Two loads (16'h1111 then 16'h2222) in one frame: only 2222 is ever displayed; load in the boundary cycle is committed at that boundary.
- enable dropped mid-slot: next cycle AN=1111 and display=7'h7F, no frame_done; on re-enable, scanning restarts at digit 3.
- With SEG_LZB_EN, number=16'h0045, dp=4'b0010: AN[3] and AN[2] slots show 7'h7F; AN[1]="4" with dp_n=0; AN[0]="5". With number=0, only digit 0 shows "0".
